// File: rtl/reg_wb_arbiter_pkg.sv
// Shared register-file constants and the
// write-back arbiter defaults.
package reg_wb_arbiter_pkg;

    localparam int REGISTER_FILE_ADDRESS_LEN = 4;
    localparam int REGISTER_FILE_LEN = 1 << REGISTER_FILE_ADDRESS_LEN;
    localparam int REGISTER_FILE_SIZE = 32;
    localparam int WB_FIFO_DEPTH = 4;

    // A counter must hold 0..depth pending writes.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/reg_wb_arbiter_wb_fifo.sv
// Port B result buffer: synchronous FIFO with
// extra-bit wrap pointers.
module wb_fifo
    import reg_wb_arbiter_pkg::*;
#(
    parameter int W = REGISTER_FILE_ADDRESS_LEN + REGISTER_FILE_SIZE,
    parameter int DEPTH = WB_FIFO_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0]  wr_ptr;
    logic [PW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];
    logic         do_push;
    logic         do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                   (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign rdata = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PW-1:0]] <= wdata;
    end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Register-file write-port arbiter: port A priority,
// buffered port B, per-register pending scoreboard.
module reg_wb_arbiter
    import reg_wb_arbiter_pkg::*;
#(
    parameter int ADDR_W = REGISTER_FILE_ADDRESS_LEN,
    parameter int DATA_W = REGISTER_FILE_SIZE,
    parameter int DEPTH  = WB_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_en,
    input  logic [ADDR_W-1:0] a_dest,
    input  logic [DATA_W-1:0] a_value,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_dest,
    input  logic [DATA_W-1:0] b_value,
    output logic              wb_en,
    output logic [ADDR_W-1:0] wb_dest,
    output logic [DATA_W-1:0] wb_value,
    input  logic [ADDR_W-1:0] q_addr_1,
    input  logic [ADDR_W-1:0] q_addr_2,
    output logic              busy_1,
    output logic              busy_2,
    output logic              order_err
);

    localparam int CNT_W = cnt_width(DEPTH);
    localparam int NREG  = 1 << ADDR_W;
    localparam int ENT_W = ADDR_W + DATA_W;

    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic [ENT_W-1:0]  head;
    logic [ADDR_W-1:0] head_dest;
    logic [DATA_W-1:0] head_value;
    logic [NREG-1:0]   inc;
    logic [NREG-1:0]   dec;
    logic [CNT_W-1:0]  pend [NREG];

    assign b_ready = rst & ~fifo_full;
    assign push    = b_valid & b_ready;
    assign pop     = ~a_en & ~fifo_empty;
    assign {head_dest, head_value} = head;

    wb_fifo #(
        .W     (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({b_dest, b_value}),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        inc = '0;
        dec = '0;
        for (int i = 0; i < NREG; i++) begin
            inc[i] = push && (b_dest == ADDR_W'(i));
            dec[i] = pop && (head_dest == ADDR_W'(i));
        end
    end

    // Simultaneous inc/dec on one register cancels out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) pend[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (inc[i] && !dec[i])
                    pend[i] <= pend[i] + CNT_W'(1);
                else if (dec[i] && !inc[i])
                    pend[i] <= pend[i] - CNT_W'(1);
            end
        end
    end

    assign busy_1 = |pend[q_addr_1];
    assign busy_2 = |pend[q_addr_2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_en    <= 1'b0;
            wb_dest  <= '0;
            wb_value <= '0;
        end else if (a_en) begin
            wb_en    <= 1'b1;
            wb_dest  <= a_dest;
            wb_value <= a_value;
        end else if (!fifo_empty) begin
            wb_en    <= 1'b1;
            wb_dest  <= head_dest;
            wb_value <= head_value;
        end else begin
            wb_en    <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            order_err <= 1'b0;
        else if (a_en && |pend[a_dest])
            order_err <= 1'b1;
    end

endmodule

// File: doc/reg_wb_arbiter.md
# reg_wb_arbiter

Write-port arbiter and scoreboard for the 16×32 register file. It shares the single register-file write port between the pipeline writeback stage (port A, never stalls) and a late-result source such as a multi-cycle unit or slow memory (port B, valid/ready). Port B results are buffered in a small FIFO and drained into idle write slots. Per-register pending-write counters feed busy flags to the hazard unit.

## Interface
- `ADDR_W`, default 4: register address width.
- `DATA_W`, default 32: register data width.
- `DEPTH`, default 4: port B FIFO depth; power of two, at least 2.
- `clk` in 1: single clock. All state updates on posedge.
- `rst` in 1: asynchronous, active-low reset.
- `a_en` in 1: port A write request. Always accepted.
- `a_dest` in ADDR_W: port A destination.
- `a_value` in DATA_W: port A data.
- `b_valid` in 1: port B write request.
- `b_ready` out 1: port B accept. Equals !fifo_full and is forced 0 while `rst` is low.
- `b_dest` in ADDR_W: port B destination.
- `b_value` in DATA_W: port B data.
- `wb_en` out 1: registered write enable to the register file.
- `wb_dest` out ADDR_W: registered write address.
- `wb_value` out DATA_W: registered write data.
- `q_addr_1`, `q_addr_2` in ADDR_W: hazard query addresses.
- `busy_1`, `busy_2` out 1: combinational. High when the pending counter of the queried register is non-zero.
- `order_err` out 1: sticky error flag, cleared only by reset.

## Operation
- **Port B accept:** occurs at a posedge where `b_valid & b_ready`. The entry {dest, value} is pushed to the FIFO, and `pend[b_dest]` increments.
- **Issue decision:** made every posedge, in priority order.
  - If `a_en` is high, the output register loads {1, `a_dest`, `a_value`}.
  - Otherwise, if the FIFO is not empty, the output register loads the FIFO head. The head is popped and `pend[head.dest]` decrements.
  - Otherwise `wb_en` loads 0. `wb_dest` and `wb_value` hold their previous values.
- **Port A has strict priority.** Port B can starve under continuous `a_en`. This is accepted, because the pipeline bubbles whenever it stalls.
- **Counter update on the same register in the same cycle:**
  - Increment and decrement together leave the counter unchanged.
  - Counter width is clog2(DEPTH+1). The FIFO bound makes overflow impossible.
- **Push and pop in the same cycle on a full FIFO:**
  - `b_ready` is 0 when the FIFO is full, so no push occurs. The pop still proceeds.
  - The FIFO needs no bypass. An entry is never pushed and issued in the same cycle.
- **Ordering rule:** the pipeline must not issue a port A write to a register with a pending port B write. The hazard unit enforces this through `busy_*`.
  - If `a_en` is high while `pend[a_dest]` is non-zero, set `order_err`.
  - The write is still performed.
- **Reset (`rst` low):**
  - FIFO pointers cleared; all `pend` counters 0.
  - `wb_en` = 0, `wb_dest` = 0, `wb_value` = 0, `order_err` = 0, `b_ready` = 0.
  - Reset asserted mid-operation discards all queued port B entries without writing them.

## Timing
- **Port A latency:** `a_en` sampled at posedge n gives `wb_en` high during cycle n+1. The register file commits at the negedge inside cycle n+1.
- **Port B minimum latency:**
  - Accept at posedge n, issue at posedge n+1 if `a_en` is low, `wb_en` high during cycle n+2.
  - Each cycle in which `a_en` is high adds one cycle.
- **Busy flag:** `busy` rises in the cycle after the accepting posedge and falls in the cycle after the issuing posedge. The data commits at the negedge of that cycle, so a same-cycle combinational read after the negedge sees the new value.
- **Throughput:** one register-file write per cycle. Port B sustains one per cycle when port A is idle.
- **`b_ready`:** combinational from FIFO occupancy only, with no dependency on `b_valid`.

## Structure
- Put `REGISTER_FILE_ADDRESS_LEN`, `REGISTER_FILE_LEN` and `REGISTER_FILE_SIZE` in the shared constants file. Also add `WB_FIFO_DEPTH` there as the default for `DEPTH`.
- Add one sub-module, `wb_fifo`: a synchronous FIFO with width ADDR_W+DATA_W, depth DEPTH, extra-bit wrap pointers, full/empty flags and the same asynchronous active-low reset.
- The following stay in `reg_wb_arbiter`:
  - pending counter array;
  - issue mux;
  - output register;
  - error flag.

## Test plan
- **Reset:** drive `rst` low mid-stream with 3 port B entries queued. Require `wb_en` = 0, `b_ready` = 0 and all `busy` = 0 immediately. After release, require no write of the discarded entries and `b_ready` = 1.
- **Port A alone:** `a_en` with dest 5, value 0x1234 at posedge n. Require `wb_en` = 1, `wb_dest` = 5, `wb_value` = 0x1234 in cycle n+1 and `wb_en` = 0 in n+2.
- **Port B alone:** accept dest 3, value 0xAA at posedge n. Require `busy` for register 3 high in cycle n+1, `wb_en` with 3/0xAA in n+2, and `busy` low in n+2.
- **Starvation then drain:**
  - Hold `a_en` for 6 cycles while offering 5 port B writes to registers 1–5.
  - Require `b_ready` to fall after the 4th accept.
  - Require the port B entries to drain in order 1,2,3,4, then 5 once `a_en` drops.
- **Duplicate destination:** two port B writes to register 7, values 1 then 2. Require `busy` held until the second issue, the final register value 2, and `pend` returning to 0.
- **Order violation:** `a_en` to register 7 while its port B write is pending. Require `order_err` to rise and stay high until reset, and the port A write to occur.
